// File: rtl/reg4_write_arbiter_if.sv
// Bus bundle between the producer blocks and the shared-register write arbiter.
// The requester side drives req/wdata; the arbiter drives grant/q/busy/wr_count.
interface reg4_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       grant;
  logic [WIDTH-1:0]         q;
  logic                     busy;
  logic [7:0]               wr_count;

  modport master (
    output req, wdata,
    input  grant, q, busy, wr_count
  );

  modport slave (
    input  req, wdata,
    output grant, q, busy, wr_count
  );
endinterface

// File: rtl/reg4_write_arbiter.sv
// Round-robin write arbiter for a shared register: grants one requester per
// write cycle, loads its value into q on the closing edge of that cycle, and
// counts completed writes. The requester granted in a cycle is excluded from
// the arbitration for the following cycle, so a held request is served every
// other cycle at most.
module reg4_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input logic                clk,
  input logic                reset,
  reg4_write_arbiter_if.slave bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]         state;
  logic [IW-1:0]      g;
  logic [IW-1:0]      ptr;
  logic [WIDTH-1:0]   q;
  logic [7:0]         wr_count;

  logic [IW-1:0]      start;
  logic [IW-1:0]      winner;
  logic               found;
  logic [NUM_REQ-1:0] eligible;
  logic [WIDTH-1:0]   sel_data;

  // Index increment with explicit wrap, since NUM_REQ need not be a power of two.
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] v);
    if (v == IW'(NUM_REQ - 1)) begin
      return '0;
    end
    return v + IW'(1);
  endfunction

  // Round-robin search. While granting, the search starts at the pointer value
  // that the current grant will leave behind (g+1), and g itself is masked out.
  always_comb begin
    logic [IW-1:0] idx;
    eligible = bus.req;
    start    = ptr;
    if (state == GRANT) begin
      eligible[g] = 1'b0;
      start       = inc(g);
    end
    found  = 1'b0;
    winner = '0;
    idx    = start;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = inc(idx);
    end
  end

  // Select the granted requester's write value.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (g == IW'(i)) begin
        sel_data = bus.wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // FSM, grant index, pointer, shared register and write counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      g        <= '0;
      ptr      <= '0;
      q        <= '0;
      wr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            g     <= winner;
            state <= GRANT;
          end
        end
        GRANT: begin
          q        <= sel_data;
          wr_count <= wr_count + 8'd1;
          ptr      <= inc(g);
          if (found) begin
            g <= winner;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from registers only.
  always_comb begin
    bus.grant = '0;
    if (state == GRANT) begin
      bus.grant[g] = 1'b1;
    end
    bus.busy     = (state == GRANT);
    bus.q        = q;
    bus.wr_count = wr_count;
  end

endmodule

// File: tb/tb_reg4_write_arbiter.sv
// Self-checking bench for reg4_write_arbiter: a cycle-level behavioural model
// checked against the DUT on every falling edge, plus directed scenarios with
// literal expectations.
module tb_reg4_write_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NUM_REQ-1:0] one_shot = '0;

  int checks = 0;
  int errors = 0;

  reg4_write_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  reg4_write_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: current grant index (-1 = none), round-robin start, register, count.
  int         cur_m = -1;
  int         ptr_m = 0;
  logic [3:0] q_m   = '0;
  logic [7:0] cnt_m = '0;

  always @(posedge clk or posedge reset) begin
    int start;
    int excl;
    int nxt;
    int idx;
    if (reset) begin
      cur_m = -1;
      ptr_m = 0;
      q_m   = '0;
      cnt_m = '0;
    end else begin
      start = ptr_m;
      excl  = -1;
      if (cur_m >= 0) begin
        q_m   = bus.wdata[cur_m*WIDTH +: WIDTH];
        cnt_m = cnt_m + 8'd1;
        ptr_m = (cur_m + 1) % NUM_REQ;
        start = ptr_m;
        excl  = cur_m;
      end
      nxt = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (start + k) % NUM_REQ;
        if (nxt < 0 && idx != excl && bus.req[idx]) nxt = idx;
      end
      cur_m = nxt;
    end
  end

  // Compare DUT outputs with the model every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] eg;
    eg = '0;
    if (cur_m >= 0) eg[cur_m] = 1'b1;
    check("model_grant", 32'(bus.grant), 32'(eg));
    check("model_busy", 32'(bus.busy), 32'(cur_m >= 0));
    check("model_q", 32'(bus.q), 32'(q_m));
    check("model_wr_count", 32'(bus.wr_count), 32'(cnt_m));
  end

  // Advance one cycle; requesters in one_shot mode drop req in the cycle after grant.
  task automatic tick();
    logic [NUM_REQ-1:0] seen;
    @(negedge clk);
    seen = bus.grant;
    @(posedge clk);
    #1;
    bus.req = bus.req & ~(seen & one_shot);
  endtask

  task automatic do_reset();
    bus.req  = '0;
    one_shot = '0;
    reset    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_REQ-1:0] prev;
    logic [NUM_REQ-1:0] exp_fair [4];
    int busy_cycles;
    bit saw5;
    bus.req   = '0;
    bus.wdata = '0;
    #1 reset = 1'b1;
    #1;
    check("reset_grant", 32'(bus.grant), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_q", 32'(bus.q), 32'h0);
    check("reset_wr_count", 32'(bus.wr_count), 32'h0);
    tick();
    reset = 1'b0;

    // Isolated write.
    bus.req = 4'b0001;
    bus.wdata[0*WIDTH +: WIDTH] = 4'hA;
    one_shot = 4'b0001;
    tick();
    check("iso_grant", 32'(bus.grant), 32'h1);
    check("iso_busy", 32'(bus.busy), 32'h1);
    tick();
    check("iso_q", 32'(bus.q), 32'hA);
    check("iso_count", 32'(bus.wr_count), 32'h1);
    check("iso_busy_low", 32'(bus.busy), 32'h0);
    tick();
    check("iso_idle", 32'(bus.grant), 32'h0);

    // All four requesting from reset.
    do_reset();
    bus.req   = 4'b1111;
    bus.wdata = {4'h4, 4'h3, 4'h2, 4'h1};
    one_shot  = 4'b1111;
    busy_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.busy) busy_cycles++;
      check("all4_grant", 32'(bus.grant), 32'(1) << k);
      check("all4_q", 32'(bus.q), 32'(k));
    end
    tick();
    if (bus.busy) busy_cycles++;
    tick();
    if (bus.busy) busy_cycles++;
    check("all4_q_final", 32'(bus.q), 32'h4);
    check("all4_count", 32'(bus.wr_count), 32'h4);
    check("all4_busy_cycles", 32'(busy_cycles), 32'd4);

    // Fairness: req0 held, req2 pulsed.
    bus.req = 4'b0101;
    bus.wdata[0*WIDTH +: WIDTH] = 4'h3;
    bus.wdata[2*WIDTH +: WIDTH] = 4'h5;
    one_shot = 4'b0100;
    exp_fair = '{4'b0001, 4'b0100, 4'b0001, 4'b0000};
    prev = '0;
    saw5 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k < 4) check("fair_grant", 32'(bus.grant), 32'(exp_fair[k]));
      if (k == 2) check("fair_q5", 32'(bus.q), 32'h5);
      check("fair_no_repeat", 32'(prev == 4'b0001 && bus.grant == 4'b0001), 32'h0);
      if (bus.q == 4'h5) saw5 = 1'b1;
      prev = bus.grant;
    end
    check("fair_saw5", 32'(saw5), 32'h1);
    bus.req  = '0;
    one_shot = '0;
    tick();
    tick();

    // Pointer wrap: grant to 2 leaves ptr at 3, then 3 beats 0.
    do_reset();
    bus.req = 4'b0100;
    bus.wdata[2*WIDTH +: WIDTH] = 4'h6;
    one_shot = 4'b0100;
    tick();
    check("wrap_pre_grant", 32'(bus.grant), 32'h4);
    tick();
    tick();
    check("wrap_pre_q", 32'(bus.q), 32'h6);
    bus.req = 4'b1001;
    bus.wdata[3*WIDTH +: WIDTH] = 4'h9;
    bus.wdata[0*WIDTH +: WIDTH] = 4'h1;
    one_shot = 4'b1001;
    tick();
    check("wrap_first", 32'(bus.grant), 32'h8);
    tick();
    check("wrap_second", 32'(bus.grant), 32'h1);
    check("wrap_q9", 32'(bus.q), 32'h9);
    tick();
    check("wrap_q1", 32'(bus.q), 32'h1);
    check("wrap_idle", 32'(bus.grant), 32'h0);

    // Asynchronous reset in the middle of a grant cycle.
    bus.req = 4'b0010;
    bus.wdata[1*WIDTH +: WIDTH] = 4'h7;
    one_shot = 4'b0010;
    tick();
    check("areset_pre_grant", 32'(bus.grant), 32'h2);
    #2 reset = 1'b1;
    #1;
    check("areset_grant", 32'(bus.grant), 32'h0);
    check("areset_busy", 32'(bus.busy), 32'h0);
    check("areset_q", 32'(bus.q), 32'h0);
    check("areset_count", 32'(bus.wr_count), 32'h0);
    tick();
    check("areset_held_q", 32'(bus.q), 32'h0);
    check("areset_held_count", 32'(bus.wr_count), 32'h0);
    check("areset_held_busy", 32'(bus.busy), 32'h0);
    bus.req  = '0;
    one_shot = '0;
    reset    = 1'b0;
    tick();

    // 256 single writes: counter wraps to 0.
    for (int i = 0; i < 256; i++) begin
      bus.req = 4'b0010;
      bus.wdata[1*WIDTH +: WIDTH] = 4'(i);
      one_shot = 4'b0010;
      tick();
      tick();
      tick();
      if (i == 254) check("cnt_255", 32'(bus.wr_count), 32'd255);
    end
    check("cnt_wrap", 32'(bus.wr_count), 32'h0);
    check("cnt_last_q", 32'(bus.q), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
